// File: rtl/mac_pkg.sv
// mac_pkg: shared mode encodings, readback addresses and signed range helpers for mac_pe
package mac_pkg;
    typedef enum logic {MODE_WS = 1'b0, MODE_OS = 1'b1} mode_e;
    localparam logic [2:0] JA_WEIGHT = 3'd0;
    localparam logic [2:0] JA_SHADOW = 3'd1;
    localparam logic [2:0] JA_DATA = 3'd2;
    localparam logic [2:0] JA_PSUM = 3'd3;
    localparam logic [2:0] JA_ACC = 3'd4;
    localparam logic [2:0] JA_RES = 3'd5;
    localparam logic [2:0] JA_STAT = 3'd6;
    function automatic logic signed [63:0] smax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction
    function automatic logic signed [63:0] smin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction
endpackage

// File: rtl/booth_randix4_mul.sv
// booth_randix4_mul: combinational signed radix-4 Booth multiplier
module booth_randix4_mul #(
    parameter int W = 8
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);
    localparam int N = (W + 1) / 2;
    logic signed [2*N:0] bx;
    logic signed [2*W-1:0] ax;
    logic signed [2*W-1:0] mag;
    logic signed [2*W-1:0] pp;
    logic [2:0] sel;
    assign bx = (2*N+1)'($signed({b, 1'b0}));
    assign ax = (2*W)'(a);
    always_comb begin
        p = '0;
        sel = '0;
        mag = '0;
        pp = '0;
        for (int i = 0; i < N; i++) begin
            sel = bx[2*i+2 -: 3];
            mag = (sel[1] ^ sel[0]) ? ax : (sel[2] ^ sel[1]) ? ax <<< 1 : '0;
            pp = sel[2] ? -mag : mag;
            p = p + (pp <<< (2 * i));
        end
    end
endmodule

// File: rtl/sat_add.sv
// sat_add: exact signed add of two IN_W operands, clamped to OUT_W with a clamp flag
module sat_add
    import mac_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);
    localparam logic signed [IN_W:0] HI = (IN_W+1)'(smax(OUT_W));
    localparam logic signed [IN_W:0] LO = (IN_W+1)'(smin(OUT_W));
    logic signed [IN_W:0] sum;
    assign sum = (IN_W+1)'(a) + (IN_W+1)'(b);
    assign y = sum > HI ? OUT_W'(HI) : sum < LO ? OUT_W'(LO) : OUT_W'(sum);
    assign sat = sum > HI || sum < LO;
endmodule

// File: rtl/mac_pe.sv
// mac_pe: systolic PE with double-buffered weight, WS/OS modes and saturating accumulate
module mac_pe
    import mac_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step_i,
    input  logic                    mode_i,
    input  logic signed [W-1:0]     data_i,
    input  logic signed [ACC_W-1:0] psum_i,
    input  logic                    wr_weight_v_i,
    input  logic signed [W-1:0]     weight_i,
    input  logic                    swap_i,
    input  logic                    drain_i,
    input  logic                    clear_sat_i,
    input  logic [2:0]              jtag_ureg_addr_i,
    output logic [ACC_W-1:0]        jtag_ureg_data_o,
    output logic signed [W-1:0]     data_o,
    output logic signed [ACC_W-1:0] res_o,
    output logic                    res_v_o,
    output logic                    sat_o
);
    localparam int E = (2 * W > ACC_W) ? 2 * W : ACC_W;
    logic signed [W-1:0] data_q, weight_q, shadow_q;
    logic signed [ACC_W-1:0] psum_q, acc_q, res_q;
    logic res_v_q, sat_q;
    mode_e mode_q;
    logic signed [2*W-1:0] mul;
    logic signed [ACC_W-1:0] ps_res, acc_res;
    logic ps_sat, acc_sat, upd, sat_set;
    booth_randix4_mul #(.W(W)) u_mul (.a(weight_q), .b(data_q), .p(mul));
    sat_add #(.IN_W(E), .OUT_W(ACC_W)) u_ps (.a(E'(mul)), .b(E'(psum_q)), .y(ps_res), .sat(ps_sat));
    sat_add #(.IN_W(E), .OUT_W(ACC_W)) u_acc (.a(E'(acc_q)), .b(E'(mul)), .y(acc_res), .sat(acc_sat));
    // a pending mode change suppresses the compute update for one cycle
    assign upd = step_i && (mode_i == mode_q);
    assign sat_set = upd && (mode_q == MODE_WS ? ps_sat : acc_sat);
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            psum_q <= '0;
            weight_q <= '0;
            shadow_q <= '0;
            acc_q <= '0;
            res_q <= '0;
            res_v_q <= 1'b0;
            sat_q <= 1'b0;
            mode_q <= MODE_WS;
        end else begin
            mode_q <= mode_e'(mode_i);
            if (step_i) begin
                data_q <= data_i;
                psum_q <= psum_i;
            end
            if (wr_weight_v_i) shadow_q <= weight_i;
            if (swap_i) weight_q <= wr_weight_v_i ? weight_i : shadow_q;
            sat_q <= sat_set ? 1'b1 : clear_sat_i ? 1'b0 : sat_q;
            res_v_q <= 1'b0;
            if (mode_i != mode_q) begin
                acc_q <= '0;
            end else if (step_i) begin
                if (mode_q == MODE_WS) begin
                    res_q <= ps_res;
                    res_v_q <= 1'b1;
                end else if (drain_i) begin
                    res_q <= acc_res;
                    acc_q <= '0;
                    res_v_q <= 1'b1;
                end else begin
                    acc_q <= acc_res;
                    res_q <= psum_q;
                end
            end
        end
    end
    assign data_o = data_q;
    assign res_o = res_q;
    assign res_v_o = res_v_q;
    assign sat_o = sat_q;
    always_comb begin
        jtag_ureg_data_o = '0;
        case (jtag_ureg_addr_i)
            JA_WEIGHT: jtag_ureg_data_o = ACC_W'(weight_q);
            JA_SHADOW: jtag_ureg_data_o = ACC_W'(shadow_q);
            JA_DATA:   jtag_ureg_data_o = ACC_W'(data_q);
            JA_PSUM:   jtag_ureg_data_o = psum_q;
            JA_ACC:    jtag_ureg_data_o = acc_q;
            JA_RES:    jtag_ureg_data_o = res_q;
            JA_STAT:   jtag_ureg_data_o = ACC_W'({mode_q, sat_q, res_v_q});
            default:   jtag_ureg_data_o = '0;
        endcase
    end
endmodule

// File: tb/tb_mac_pe.sv
// tb_mac_pe: directed scenario tests for mac_pe (W=8, ACC_W=16)
module tb_mac_pe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic step_i = 1'b0;
    logic mode_i = 1'b0;
    logic [7:0] data_i = '0;
    logic [15:0] psum_i = '0;
    logic wr_weight_v_i = 1'b0;
    logic [7:0] weight_i = '0;
    logic swap_i = 1'b0;
    logic drain_i = 1'b0;
    logic clear_sat_i = 1'b0;
    logic [2:0] jtag_ureg_addr_i = '0;
    logic [15:0] jtag_ureg_data_o;
    logic [7:0] data_o;
    logic [15:0] res_o;
    logic res_v_o;
    logic sat_o;
    int total = 0;
    int bad = 0;

    mac_pe #(.W(8), .ACC_W(16)) dut (
        .clk(clk), .rst(rst), .step_i(step_i), .mode_i(mode_i), .data_i(data_i),
        .psum_i(psum_i), .wr_weight_v_i(wr_weight_v_i), .weight_i(weight_i),
        .swap_i(swap_i), .drain_i(drain_i), .clear_sat_i(clear_sat_i),
        .jtag_ureg_addr_i(jtag_ureg_addr_i), .jtag_ureg_data_o(jtag_ureg_data_o),
        .data_o(data_o), .res_o(res_o), .res_v_o(res_v_o), .sat_o(sat_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_weight(input logic [7:0] w);
        wr_weight_v_i = 1'b1; swap_i = 1'b1; weight_i = w;
        tick();
        wr_weight_v_i = 1'b0; swap_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (res_o !== 16'h0) begin bad++; $display("FAIL reset_res got=%h exp=0000", res_o); end
        total++; if ({data_o, res_v_o, sat_o} !== 10'h0) begin bad++; $display("FAIL reset_outs got=%h exp=000", {data_o, res_v_o, sat_o}); end
        for (int i = 0; i < 8; i++) begin
            jtag_ureg_addr_i = 3'(i); #1;
            total++; if (jtag_ureg_data_o !== 16'h0) begin bad++; $display("FAIL reset_jtag%0d got=%h exp=0000", i, jtag_ureg_data_o); end
        end
    endtask

    task automatic test_ws_basic;
        wr_weight_v_i = 1'b1; weight_i = 8'd3;
        tick();
        wr_weight_v_i = 1'b0; swap_i = 1'b1;
        tick();
        swap_i = 1'b0;
        jtag_ureg_addr_i = 3'd0; #1;
        total++; if (jtag_ureg_data_o !== 16'd3) begin bad++; $display("FAIL ws_weight got=%h exp=0003", jtag_ureg_data_o); end
        step_i = 1'b1; data_i = 8'd5; psum_i = 16'd100;
        tick();
        total++; if (data_o !== 8'd5) begin bad++; $display("FAIL ws_data_o got=%h exp=05", data_o); end
        data_i = 8'd0; psum_i = 16'd0;
        tick();
        step_i = 1'b0;
        total++; if (res_o !== 16'd115 || res_v_o !== 1'b1) begin bad++; $display("FAIL ws_res got=%0d/%b exp=115/1", res_o, res_v_o); end
        total++; if (sat_o !== 1'b0) begin bad++; $display("FAIL ws_sat got=%b exp=0", sat_o); end
        tick();
        total++; if (res_v_o !== 1'b0 || res_o !== 16'd115) begin bad++; $display("FAIL ws_pulse got=%0d/%b exp=115/0", res_o, res_v_o); end
    endtask

    task automatic test_ws_pos_clamp;
        load_weight(8'h80);
        jtag_ureg_addr_i = 3'd0; #1;
        total++; if (jtag_ureg_data_o !== 16'hFF80) begin bad++; $display("FAIL pos_weight_sext got=%h exp=ff80", jtag_ureg_data_o); end
        step_i = 1'b1; data_i = 8'h80; psum_i = 16'h7FFF;
        tick();
        data_i = 8'd0; psum_i = 16'd0;
        tick();
        step_i = 1'b0;
        total++; if (res_o !== 16'h7FFF || sat_o !== 1'b1) begin bad++; $display("FAIL pos_clamp got=%h/%b exp=7fff/1", res_o, sat_o); end
        clear_sat_i = 1'b1;
        tick();
        clear_sat_i = 1'b0;
        total++; if (sat_o !== 1'b0) begin bad++; $display("FAIL pos_clear got=%b exp=0", sat_o); end
    endtask

    task automatic test_ws_neg_clamp;
        load_weight(8'd127);
        step_i = 1'b1; data_i = 8'h80; psum_i = 16'h8000;
        tick();
        data_i = 8'd0; psum_i = 16'd0;
        tick();
        step_i = 1'b0;
        total++; if (res_o !== 16'h8000 || sat_o !== 1'b1) begin bad++; $display("FAIL neg_clamp got=%h/%b exp=8000/1", res_o, sat_o); end
        clear_sat_i = 1'b1; step_i = 1'b1;
        tick();
        clear_sat_i = 1'b0; step_i = 1'b0;
        total++; if (sat_o !== 1'b0 || res_o !== 16'h0) begin bad++; $display("FAIL neg_noclamp got=%h/%b exp=0000/0", res_o, sat_o); end
    endtask

    task automatic test_double_buffer;
        load_weight(8'd2);
        wr_weight_v_i = 1'b1; weight_i = 8'd7;
        tick();
        wr_weight_v_i = 1'b0;
        jtag_ureg_addr_i = 3'd1; #1;
        total++; if (jtag_ureg_data_o !== 16'd7) begin bad++; $display("FAIL db_shadow got=%h exp=0007", jtag_ureg_data_o); end
        step_i = 1'b1; data_i = 8'd4; psum_i = 16'd0;
        tick();
        data_i = 8'd0;
        tick();
        step_i = 1'b0;
        total++; if (res_o !== 16'd8) begin bad++; $display("FAIL db_old_weight got=%0d exp=8", res_o); end
        swap_i = 1'b1;
        tick();
        swap_i = 1'b0;
        jtag_ureg_addr_i = 3'd0; #1;
        total++; if (jtag_ureg_data_o !== 16'd7) begin bad++; $display("FAIL db_swap got=%h exp=0007", jtag_ureg_data_o); end
        load_weight(8'd9);
        total++; if (jtag_ureg_data_o !== 16'd9) begin bad++; $display("FAIL db_bypass got=%h exp=0009", jtag_ureg_data_o); end
        jtag_ureg_addr_i = 3'd1; #1;
        total++; if (jtag_ureg_data_o !== 16'd9) begin bad++; $display("FAIL db_bypass_shadow got=%h exp=0009", jtag_ureg_data_o); end
    endtask

    task automatic test_os_drain;
        logic [15:0] exp_acc [5] = '{16'd0, 16'd2, 16'd6, 16'd12, 16'd20};
        logic [15:0] exp_res [5] = '{16'd0, 16'd11, 16'd12, 16'd13, 16'd14};
        mode_i = 1'b1;
        tick(); tick();
        load_weight(8'd2);
        for (int i = 0; i < 5; i++) begin
            step_i = 1'b1; data_i = 8'(i + 1); psum_i = 16'(i + 11);
            tick();
            jtag_ureg_addr_i = 3'd4; #1;
            total++; if (jtag_ureg_data_o !== exp_acc[i]) begin bad++; $display("FAIL os_acc%0d got=%0d exp=%0d", i, jtag_ureg_data_o, exp_acc[i]); end
            total++; if (res_o !== exp_res[i] || res_v_o !== 1'b0) begin bad++; $display("FAIL os_pass%0d got=%0d/%b exp=%0d/0", i, res_o, res_v_o, exp_res[i]); end
        end
        drain_i = 1'b1; data_i = 8'd0; psum_i = 16'd0;
        tick();
        drain_i = 1'b0; step_i = 1'b0;
        total++; if (res_o !== 16'd30 || res_v_o !== 1'b1) begin bad++; $display("FAIL os_drain got=%0d/%b exp=30/1", res_o, res_v_o); end
        #1;
        total++; if (jtag_ureg_data_o !== 16'd0) begin bad++; $display("FAIL os_drain_acc got=%0d exp=0", jtag_ureg_data_o); end
    endtask

    task automatic test_reset_mid_os;
        step_i = 1'b1; data_i = 8'd6;
        tick();
        data_i = 8'd0;
        tick();
        step_i = 1'b0;
        jtag_ureg_addr_i = 3'd4; #1;
        total++; if (jtag_ureg_data_o !== 16'd12) begin bad++; $display("FAIL mid_acc got=%0d exp=12", jtag_ureg_data_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({data_o, res_o, res_v_o, sat_o} !== 26'h0) begin bad++; $display("FAIL mid_outs got=%h exp=0", {data_o, res_o, res_v_o, sat_o}); end
        for (int i = 0; i < 7; i++) begin
            jtag_ureg_addr_i = 3'(i); #1;
            total++; if (jtag_ureg_data_o !== 16'h0) begin bad++; $display("FAIL mid_jtag%0d got=%h exp=0000", i, jtag_ureg_data_o); end
        end
    endtask

    task automatic test_mode_toggle;
        tick();
        load_weight(8'd2);
        step_i = 1'b1; data_i = 8'd3;
        tick();
        data_i = 8'd0;
        tick();
        step_i = 1'b0;
        jtag_ureg_addr_i = 3'd4; #1;
        total++; if (jtag_ureg_data_o !== 16'd6) begin bad++; $display("FAIL tog_acc got=%0d exp=6", jtag_ureg_data_o); end
        jtag_ureg_addr_i = 3'd6; #1;
        total++; if (jtag_ureg_data_o !== 16'h4) begin bad++; $display("FAIL tog_stat got=%h exp=0004", jtag_ureg_data_o); end
        mode_i = 1'b0;
        tick();
        jtag_ureg_addr_i = 3'd4; #1;
        total++; if (jtag_ureg_data_o !== 16'd0 || res_v_o !== 1'b0) begin bad++; $display("FAIL tog_clear got=%0d/%b exp=0/0", jtag_ureg_data_o, res_v_o); end
    endtask

    initial begin
        test_reset();
        test_ws_basic();
        test_ws_pos_clamp();
        test_ws_neg_clamp();
        test_double_buffer();
        test_os_drain();
        test_reset_mid_os();
        test_mode_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mac_pe.md
Name: mac_pe

Overview:
- Next-generation systolic-array processing element: signed multiply of streamed data by a stationary weight, plus a partial-sum add.
- Parametrised data and accumulator widths.
- Double-buffered weights, so a new weight loads while the current one computes.
- Two runtime modes: weight-stationary (WS: add to the partial sum from above) and output-stationary (OS: accumulate locally, drain on command).
- Saturating arithmetic with a sticky flag; registered result with valid; JTAG user-register readback.

Parameters:
- W, 8, signed data/weight width.
- ACC_W, 16, signed partial-sum/accumulator width; constraint ACC_W >= W+1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- step_i  in  1  advance enable for the data/psum/result/accumulator pipeline
- mode_i  in  1  0=WS, 1=OS; quasi-static
- data_i  in  W  right-side input data
- psum_i  in  ACC_W  partial sum from the PE above
- wr_weight_v_i  in  1  write weight_i into the shadow weight
- weight_i  in  W  weight value
- swap_i  in  1  copy shadow weight to active weight
- drain_i  in  1  OS only: emit accumulator on this step
- clear_sat_i  in  1  clear sticky saturation flag
- jtag_ureg_addr_i  in  3  readback select
- jtag_ureg_data_o  out  ACC_W  readback data
- data_o  out  W  registered data to the left neighbour
- res_o  out  ACC_W  registered result to the PE below
- res_v_o  out  1  result-valid pulse
- sat_o  out  1  sticky saturation flag

Behaviour:
- Reset: all registers clear to 0. This covers data_q, psum_q, weight_q, shadow_q, acc_q, res_q, res_v_q, sat_q and mode_q. All outputs are 0.
- Step registers: on step_i, data_q<=data_i and psum_q<=psum_i. Hold when step_i=0.
- Output wiring: data_o=data_q, res_o=res_q, res_v_o=res_v_q, sat_o=sat_q.
- Product: mul = weight_q*data_q, signed, 2W bits, combinational from the registers.
- Saturating add: sat(a+b) sign-extends both operands to max(2W,ACC_W)+1 bits and adds exactly. A result above 2^(ACC_W-1)-1 clamps to MAX; below -2^(ACC_W-1) clamps to MIN. A clamp raises sat_evt.
- WS mode, on step: res_q<=sat(mul+psum_q) and res_v_q<=1. Latency from data_i/psum_i sampled to res_o is 2 steps.
- OS mode, step with drain_i=0: acc_q<=sat(acc_q+mul); res_q<=psum_q (pass-through of drained values from above); res_v_q<=0.
- OS mode, step with drain_i=1: res_q<=sat(acc_q+mul); acc_q<=0; res_v_q<=1.
- No step: res_v_q<=0 and acc_q/res_q hold. res_v_o is therefore a 1-cycle pulse.
- drain_i is ignored in WS mode.
- Mode register: mode_q<=mode_i every cycle; all mode decisions use mode_q. When mode_i!=mode_q, acc_q<=0 and res_v_q<=0 next cycle, taking priority over the step update.
- Weights: wr_weight_v_i gives shadow_q<=weight_i. swap_i gives weight_q<=shadow_q. Both act any cycle, independent of step_i.
- Simultaneous wr_weight_v_i and swap_i: weight_q<=weight_i (bypass) and shadow_q<=weight_i.
- Sticky flag: sat_q<=1 on any step where sat_evt is used for an update; clear_sat_i clears it. Simultaneous set and clear: set wins.
- JTAG readback is combinational, intended for use with step_i held low. W-wide values are sign-extended to ACC_W.
  - 0 weight_q
  - 1 shadow_q
  - 2 data_q
  - 3 psum_q
  - 4 acc_q
  - 5 res_q
  - 6 {0…, mode_q, sat_q, res_v_q}
  - 7 zero
- Reset mid-operation: all state is discarded, including the accumulator and both weights.

Decomposition:
- mac_pkg holds:
  - mode encodings MODE_WS/MODE_OS;
  - JTAG address constants;
  - functions for signed MAX/MIN of a width.
- Sub-module sat_add #(IN_W, OUT_W): exact signed add, then clamp, with a sat flag out. It is instantiated twice, once for the psum path and once for the accumulator path.
- The product reuses the existing booth_randix4_mul at width W.

Test Plan (W=8, ACC_W=16):
- WS basic: weight 3 swapped in; step with data 5, psum 100; step again → res_o=115, res_v_o=1 for exactly one cycle; sat_o=0.
- WS positive clamp: weight -128, data -128 (mul 16384), psum 32767 → res_o=0x7FFF, sat_o=1. Pulse clear_sat_i → sat_o=0.
- WS negative clamp: weight 127, data -128, psum -32768 → res_o=0x8000.
- Double buffer: active weight 2; write shadow 7 and steps keep using 2 (data 4 → mul 8); swap_i → weight_q=7 next cycle. Same-cycle wr 9 + swap → weight_q=9.
- OS accumulate/drain: weight 2; step with data 1,2,3,4 (acc=20); drain step with data 5 → res_o=30, res_v_o=1, acc_q=0. Non-drain steps: res_o=previous psum_i, res_v_o=0.
- Reset/mode change mid-OS: acc_q=12, then rst=1 for one cycle → all outputs 0, JTAG addr 0..6 read 0. Separately, toggling mode_i with acc_q≠0 → acc_q=0 next cycle.
